// File: rtl/sync_fifo_pkg.sv
// rtl/sync_fifo_pkg.sv - shared width helper and status struct for the sync FIFO
//
// Purpose : common declarations for sync_fifo_ctrl and sync_fifo_mem.
// Contents: cnt_w(depth)   - width of pointers and occupancy count
//           fifo_status_t  - bundle of FIFO flags, convenient for flag checks
package sync_fifo_pkg;

  // One extra bit over the address width so that both full (DEPTH) and
  // empty (0) are representable, and pointers wrap modulo 2*DEPTH.
  function automatic int cnt_w(input int depth);
    return $clog2(depth) + 1;
  endfunction

  typedef struct packed {
    logic full;
    logic empty;
    logic almost_full;
    logic almost_empty;
    logic overflow;
    logic underflow;
  } fifo_status_t;

endpackage

// File: rtl/sync_fifo_mem.sv
// rtl/sync_fifo_mem.sv - FIFO storage array, one write port and one read port
//
// Purpose : DEPTH x DATA_W storage. Read port is registered by default, or
//           asynchronous (head fall-through) when SYNC_FIFO_FWFT_EN is defined.
// Ports   : clk, rst            clock, async active-high reset (read register only)
//           wr_en/wr_addr/wr_data  write port
//           rd_en/rd_addr       read strobe and address
//           rd_data             read word
module sync_fifo_mem
  #(parameter int DATA_W = 8,
    parameter int DEPTH  = 16,
    parameter int AW     = $clog2(DEPTH))
  (input  logic              clk,
   input  logic              rst,
   input  logic              wr_en,
   input  logic [AW-1:0]     wr_addr,
   input  logic [DATA_W-1:0] wr_data,
   input  logic              rd_en,
   input  logic [AW-1:0]     rd_addr,
   output logic [DATA_W-1:0] rd_data);

  // Contents are deliberately not reset; validity is tracked by the pointers.
  logic [DATA_W-1:0] mem [DEPTH];

  always_ff @(posedge clk) begin
    if (wr_en) mem[wr_addr] <= wr_data;
  end

`ifdef SYNC_FIFO_FWFT_EN
  assign rd_data = mem[rd_addr];

  logic unused_ok;
  assign unused_ok = rd_en ^ rst;
`else
  // Non-blocking read of the same address being written returns the old
  // word, which gives read-before-write when a full FIFO is read and written.
  always_ff @(posedge clk or posedge rst) begin
    if (rst)        rd_data <= '0;
    else if (rd_en) rd_data <= mem[rd_addr];
  end
`endif

endmodule

// File: rtl/sync_fifo_ctrl.sv
// rtl/sync_fifo_ctrl.sv - parametrised single-clock FIFO with count, thresholds, flush and sticky errors
//
// Purpose : pointers, occupancy count, threshold flags and error logic around
//           sync_fifo_mem. Define SYNC_FIFO_FWFT_EN for first-word-fall-through
//           reads; otherwise rd_data is registered one cycle after an accepted read.
// Ports   : clk, rst                 clock, async active-high reset
//           wr_en, wr_data           write request and word
//           rd_en                    read request (pop acknowledge in FWFT)
//           flush                    synchronous discard of all contents
//           clr_err                  clears overflow/underflow
//           rd_data, rd_valid        read word and its qualifier
//           count                    occupancy 0..DEPTH
//           full, empty              count==DEPTH / count==0
//           almost_full, almost_empty  count>=AF_LEVEL / count<=AE_LEVEL
//           overflow, underflow      sticky error flags
module sync_fifo_ctrl
  import sync_fifo_pkg::*;
  #(parameter int DATA_W   = 8,
    parameter int DEPTH    = 16,
    parameter int AF_LEVEL = DEPTH - 2,
    parameter int AE_LEVEL = 2)
  (input  logic                      clk,
   input  logic                      rst,
   input  logic                      wr_en,
   input  logic [DATA_W-1:0]         wr_data,
   input  logic                      rd_en,
   input  logic                      flush,
   input  logic                      clr_err,
   output logic [DATA_W-1:0]         rd_data,
   output logic                      rd_valid,
   output logic [cnt_w(DEPTH)-1:0]   count,
   output logic                      full,
   output logic                      empty,
   output logic                      almost_full,
   output logic                      almost_empty,
   output logic                      overflow,
   output logic                      underflow);

  localparam int CW = cnt_w(DEPTH);
  localparam int AW = CW - 1;

  logic [CW-1:0] wr_ptr;
  logic [CW-1:0] rd_ptr;
  logic          rd_acc;
  logic          wr_acc;
  logic          ovf_set;
  logic          unf_set;

  // Flags decode only the registered count, so they never see wr_en/rd_en.
  assign full         = (count == CW'(DEPTH));
  assign empty        = (count == '0);
  assign almost_full  = (count >= CW'(AF_LEVEL));
  assign almost_empty = (count <= CW'(AE_LEVEL));

  assign rd_acc = rd_en & ~empty & ~flush;
  // A full FIFO still takes a write when a read frees the head slot this cycle.
  assign wr_acc = wr_en & ~flush & (~full | rd_acc);

  assign ovf_set = wr_en & full & ~rd_acc & ~flush;
  assign unf_set = rd_en & empty & ~flush;

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      wr_ptr <= '0;
      rd_ptr <= '0;
      count  <= '0;
    end else if (flush) begin
      wr_ptr <= '0;
      rd_ptr <= '0;
      count  <= '0;
    end else begin
      if (wr_acc) wr_ptr <= wr_ptr + CW'(1);
      if (rd_acc) rd_ptr <= rd_ptr + CW'(1);
      case ({wr_acc, rd_acc})
        2'b10:   count <= count + CW'(1);
        2'b01:   count <= count - CW'(1);
        default: count <= count;
      endcase
    end
  end

  // Set beats clear when both happen in the same cycle.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      overflow  <= 1'b0;
      underflow <= 1'b0;
    end else begin
      if (ovf_set)      overflow <= 1'b1;
      else if (clr_err) overflow <= 1'b0;
      if (unf_set)      underflow <= 1'b1;
      else if (clr_err) underflow <= 1'b0;
    end
  end

`ifdef SYNC_FIFO_FWFT_EN
  assign rd_valid = ~empty;
`else
  always_ff @(posedge clk or posedge rst) begin
    if (rst)        rd_valid <= 1'b0;
    else if (flush) rd_valid <= 1'b0;
    else            rd_valid <= rd_acc;
  end
`endif

  sync_fifo_mem #(
    .DATA_W (DATA_W),
    .DEPTH  (DEPTH),
    .AW     (AW)
  ) u_mem (
    .clk     (clk),
    .rst     (rst),
    .wr_en   (wr_acc),
    .wr_addr (wr_ptr[AW-1:0]),
    .wr_data (wr_data),
    .rd_en   (rd_acc),
    .rd_addr (rd_ptr[AW-1:0]),
    .rd_data (rd_data)
  );

endmodule

// File: tb/tb_sync_fifo_ctrl.sv
// tb/tb_sync_fifo_ctrl.sv - directed self-checking bench for sync_fifo_ctrl
module tb_sync_fifo_ctrl;
  import sync_fifo_pkg::*;

  logic       clk = 1'b0;
  logic       rst = 1'b1;
  logic       wr_en = 1'b0;
  logic [7:0] wr_data = '0;
  logic       rd_en = 1'b0;
  logic       flush = 1'b0;
  logic       clr_err = 1'b0;
  logic [7:0] rd_data;
  logic       rd_valid;
  logic [4:0] count;
  logic       full, empty, almost_full, almost_empty, overflow, underflow;

  int errors = 0;
  int checks = 0;
  int mc = 0;
  logic [7:0] q[$];

  always #5 clk = ~clk;

  sync_fifo_ctrl #(.DATA_W(8), .DEPTH(16), .AF_LEVEL(14), .AE_LEVEL(2)) dut (
    .clk(clk), .rst(rst), .wr_en(wr_en), .wr_data(wr_data), .rd_en(rd_en),
    .flush(flush), .clr_err(clr_err), .rd_data(rd_data), .rd_valid(rd_valid),
    .count(count), .full(full), .empty(empty), .almost_full(almost_full),
    .almost_empty(almost_empty), .overflow(overflow), .underflow(underflow));

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
    end
  endtask

  function automatic fifo_status_t exp_st(input int c, input logic ov, input logic un);
    fifo_status_t s;
    s.full         = (c == 16);
    s.empty        = (c == 0);
    s.almost_full  = (c >= 14);
    s.almost_empty = (c <= 2);
    s.overflow     = ov;
    s.underflow    = un;
    return s;
  endfunction

  task automatic check_st(input string tag, input int c, input logic ov, input logic un);
    fifo_status_t obs;
    obs = '{full, empty, almost_full, almost_empty, overflow, underflow};
    check({tag, " count"}, 32'(count), 32'(c));
    check({tag, " flags"}, 32'(obs), 32'(exp_st(c, ov, un)));
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic cyc(input logic w, input logic r, input logic [7:0] d,
                     input logic f = 1'b0, input logic c = 1'b0);
    wr_en = w; rd_en = r; wr_data = d; flush = f; clr_err = c;
    tick();
    wr_en = 0; rd_en = 0; flush = 0; clr_err = 0;
  endtask

  task automatic pop_chk(input string tag, input logic [7:0] exp,
                         input logic w = 1'b0, input logic [7:0] d = 8'h00);
`ifdef SYNC_FIFO_FWFT_EN
    check({tag, " rd_valid"}, 32'(rd_valid), 32'd1);
    check({tag, " rd_data"}, 32'(rd_data), 32'(exp));
    cyc(w, 1'b1, d);
`else
    cyc(w, 1'b1, d);
    check({tag, " rd_valid"}, 32'(rd_valid), 32'd1);
    check({tag, " rd_data"}, 32'(rd_data), 32'(exp));
`endif
  endtask

  initial begin
    logic [7:0] d;
    logic [7:0] e;

    // Reset state
    tick(); tick();
    check_st("reset", 0, 0, 0);
    check("reset rd_valid", 32'(rd_valid), 32'd0);
`ifndef SYNC_FIFO_FWFT_EN
    check("reset rd_data", 32'(rd_data), 32'd0);
`endif
    rst = 0;
    tick();

    // Fill 0x00..0x0F, flags checked at every occupancy
    for (int i = 0; i < 16; i++) begin
      cyc(1, 0, 8'(i));
      mc++;
      check_st($sformatf("fill%0d", i), mc, 0, 0);
    end

    // Overflow: write alone while full is dropped
    cyc(1, 0, 8'hAA);
    check_st("ovf", 16, 1, 0);
    cyc(0, 0, 8'h00, 0, 1);
    check_st("clr ovf", 16, 0, 0);
    pop_chk("head after ovf", 8'h00);
    check_st("after pop0", 15, 0, 0);
    cyc(1, 0, 8'h10);
    check_st("refill", 16, 0, 0);

    // Full with simultaneous read and write: old head out, count unchanged
    pop_chk("full rw", 8'h01, 1, 8'h55);
    check_st("full rw", 16, 0, 0);

    // Drain: 0x02..0x10 then 0x55
    mc = 16;
    for (int k = 0; k < 16; k++) begin
      e = (k < 15) ? 8'(k + 2) : 8'h55;
      pop_chk($sformatf("drain%0d", k), e);
      mc--;
      check_st($sformatf("drain%0d", k), mc, 0, 0);
    end
`ifndef SYNC_FIFO_FWFT_EN
    tick();
    check("rd_valid one cycle", 32'(rd_valid), 32'd0);
`endif

    // Empty with simultaneous read and write
    cyc(1, 1, 8'h77);
    check_st("empty rw", 1, 0, 1);
`ifndef SYNC_FIFO_FWFT_EN
    check("empty rw rd_valid", 32'(rd_valid), 32'd0);
`endif
    pop_chk("empty rw word", 8'h77);
    check_st("after 77", 0, 0, 1);
    // Underflow set wins over clr_err in the same cycle
    cyc(0, 1, 8'h00, 0, 1);
    check_st("set wins", 0, 0, 1);

    // Wrap-around with a scoreboard, occupancy 4..5
    mc = 0;
    for (int i = 0; i < 4; i++) begin
      d = 8'($urandom);
      q.push_back(d);
      cyc(1, 0, d);
      mc++;
    end
    check_st("preload", 4, 0, 1);
    for (int i = 0; i < 40; i++) begin
      d = 8'($urandom);
      case (i % 3)
        0: begin
          q.push_back(d);
          cyc(1, 0, d);
          mc++;
        end
        1: begin
          e = q.pop_front();
          pop_chk($sformatf("wrap%0d", i), e);
          mc--;
        end
        default: begin
          e = q.pop_front();
          q.push_back(d);
          pop_chk($sformatf("wrap%0d", i), e, 1, d);
        end
      endcase
    end
    check_st("after wrap", 5, 0, 1);
    cyc(1, 0, 8'h01);
    cyc(1, 0, 8'h02);
    check_st("count7", 7, 0, 1);

    // Flush with wr_en: everything discarded, sticky flags untouched
    cyc(1, 0, 8'hEE, 1);
    check_st("flush", 0, 0, 1);
`ifndef SYNC_FIFO_FWFT_EN
    check("flush rd_valid", 32'(rd_valid), 32'd0);
`endif
    cyc(1, 0, 8'h33);
    check_st("post flush wr", 1, 0, 1);
    pop_chk("post flush word", 8'h33);
    cyc(0, 0, 8'h00, 0, 1);
    check_st("clr unf", 0, 0, 0);

    // Asynchronous reset mid-burst
    cyc(1, 0, 8'h11);
    cyc(1, 0, 8'h22);
    wr_en = 1; wr_data = 8'h99; rd_en = 1;
    #3;
    rst = 1;
    #1;
    check_st("async rst", 0, 0, 0);
    check("async rst rd_valid", 32'(rd_valid), 32'd0);
`ifndef SYNC_FIFO_FWFT_EN
    check("async rst rd_data", 32'(rd_data), 32'd0);
`endif
    wr_en = 0; rd_en = 0;
    tick();
    rst = 0;
    cyc(1, 0, 8'h44);
    check_st("after rst wr", 1, 0, 0);
    pop_chk("after rst word", 8'h44);

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
